// File: rtl/sal_sched_pkg.sv
// Shared scheduler types and defaults for the column-command path.
// The read credit default follows from the rdata FIFO depth and beats per read.
package sal_sched_pkg;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  localparam int AXI_ID_WIDTH     = 4;
  localparam int CNT_WIDTH_DEF    = 4;
  localparam int NUM_BANKS_DEF    = 4;
  localparam int MAX_STREAK_DEF   = 8;

  localparam int RDATA_FIFO_DEPTH = 8;
  localparam int BEATS_PER_READ   = 2;
  localparam int RD_CREDITS_DEF   = RDATA_FIFO_DEPTH / BEATS_PER_READ;

  localparam int T_CCD_DEF        = 2;
  localparam int T_WTR_DEF        = 4;
  localparam int T_RTW_DEF        = 3;

endpackage

// File: rtl/sal_rr_picker.sv
// N-way round-robin picker: first requester at or after ptr, wrapping modulo N.
module sal_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sal_cas_arbiter.sv
// Column-command arbiter: one read or write grant per cycle, tCCD/tWTR/tRTW
// spacing by down-counters, and read credits sized to the rdata FIFO.
module sal_cas_arbiter
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int RD_CREDITS = RD_CREDITS_DEF,
  parameter int MAX_STREAK = MAX_STREAK_DEF,
  localparam int CRW = $clog2(RD_CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANKS-1:0]          req_rd,
  input  logic [NUM_BANKS-1:0]          req_wr,
  input  logic [NUM_BANKS*ID_WIDTH-1:0] req_id,
  input  logic [CNT_WIDTH-1:0]          t_ccd,
  input  logic [CNT_WIDTH-1:0]          t_wtr,
  input  logic [CNT_WIDTH-1:0]          t_rtw,
  input  logic                          rd_done,
  output logic [NUM_BANKS-1:0]          bank_gnt,
  output logic                          rd_gnt,
  output logic                          wr_gnt,
  output logic [ID_WIDTH-1:0]           gnt_id,
  output logic [CRW-1:0]                credits,
  output logic                          credit_err,
  output dir_t                          dbg_dir
);

  localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);

  dir_t                 dir_q, dir_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] ccd_cnt_q, ccd_cnt_d;
  logic [CNT_WIDTH-1:0] wtr_cnt_q, wtr_cnt_d;
  logic [CNT_WIDTH-1:0] rtw_cnt_q, rtw_cnt_d;
  logic [CRW-1:0]       credits_q, credits_d;
  logic                 credit_err_q, credit_err_d;

  logic                 cur_pend, oth_pend, switch_dir;
  logic                 rd_ok, wr_ok, dir_ok, gnt_en, done_ok;
  logic [NUM_BANKS-1:0] pick_req, pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_valid;

  function automatic logic [CNT_WIDTH-1:0] load_val(input logic [CNT_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] dec_sat(input logic [CNT_WIDTH-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  sal_rr_picker #(.N(NUM_BANKS), .IW(PW)) u_picker (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q        <= DIR_RD;
      streak_q     <= '0;
      rr_ptr_q     <= '0;
      ccd_cnt_q    <= '0;
      wtr_cnt_q    <= '0;
      rtw_cnt_q    <= '0;
      credits_q    <= CRW'(RD_CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      streak_q     <= streak_d;
      rr_ptr_q     <= rr_ptr_d;
      ccd_cnt_q    <= ccd_cnt_d;
      wtr_cnt_q    <= wtr_cnt_d;
      rtw_cnt_q    <= rtw_cnt_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  // A streak-forced switch suppresses the grant in the switching cycle.
  always_comb begin
    cur_pend   = (dir_q == DIR_RD) ? |req_rd : |req_wr;
    oth_pend   = (dir_q == DIR_RD) ? |req_wr : |req_rd;
    switch_dir = oth_pend && (!cur_pend || streak_q == SW'(MAX_STREAK));
    dir_d      = dir_q;
    if (switch_dir) dir_d = (dir_q == DIR_RD) ? DIR_WR : DIR_RD;
  end

  always_comb begin
    rd_ok    = (ccd_cnt_q == '0) && (wtr_cnt_q == '0) && (credits_q != '0);
    wr_ok    = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
    pick_req = (dir_q == DIR_RD) ? req_rd : req_wr;
    dir_ok   = (dir_q == DIR_RD) ? rd_ok : wr_ok;
    gnt_en   = !rst && !switch_dir && dir_ok && pick_valid;
    bank_gnt = gnt_en ? pick_gnt : '0;
    rd_gnt   = gnt_en && (dir_q == DIR_RD);
    wr_gnt   = gnt_en && (dir_q == DIR_WR);
    gnt_id   = gnt_en ? req_id[pick_idx*ID_WIDTH +: ID_WIDTH] : '0;
  end

  always_comb begin
    streak_d = streak_q;
    if (switch_dir) streak_d = '0;
    else if (gnt_en && streak_q != SW'(MAX_STREAK)) streak_d = streak_q + 1'b1;

    rr_ptr_d = rr_ptr_q;
    if (gnt_en) rr_ptr_d = (pick_idx == PW'(NUM_BANKS - 1)) ? '0 : pick_idx + 1'b1;

    ccd_cnt_d = gnt_en ? load_val(t_ccd) : dec_sat(ccd_cnt_q);
    rtw_cnt_d = rd_gnt ? load_val(t_rtw) : dec_sat(rtw_cnt_q);
    wtr_cnt_d = wr_gnt ? load_val(t_wtr) : dec_sat(wtr_cnt_q);

    done_ok      = rd_done && (credits_q != CRW'(RD_CREDITS));
    credit_err_d = credit_err_q | (rd_done && (credits_q == CRW'(RD_CREDITS)));
    credits_d    = credits_q;
    if (rd_gnt && !done_ok) credits_d = credits_q - 1'b1;
    else if (done_ok && !rd_gnt) credits_d = credits_q + 1'b1;
  end

  assign credits    = credits_q;
  assign credit_err = credit_err_q;
  assign dbg_dir    = dir_q;

endmodule

// File: tb/tb_sal_cas_arbiter.sv
// Directed bench for sal_cas_arbiter: grant sequence, timing spacing,
// direction streak limit and read-credit accounting.
module tb_sal_cas_arbiter;
  import sal_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_rd, req_wr;
  logic [15:0] req_id;
  logic [3:0]  t_ccd, t_wtr, t_rtw;
  logic        rd_done;
  logic [3:0]  bank_gnt;
  logic        rd_gnt, wr_gnt;
  logic [3:0]  gnt_id;
  logic [2:0]  credits;
  logic        credit_err;
  dir_t        dbg_dir;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  sal_cas_arbiter dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_id(req_id),
    .t_ccd(t_ccd), .t_wtr(t_wtr), .t_rtw(t_rtw), .rd_done(rd_done),
    .bank_gnt(bank_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .gnt_id(gnt_id),
    .credits(credits), .credit_err(credit_err), .dbg_dir(dbg_dir)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check this cycle's grant outputs, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [3:0] eb, input logic er,
                     input logic ew, input logic [3:0] eid);
    #1;
    chk({tag, ".bank_gnt"}, 32'(bank_gnt), 32'(eb));
    chk({tag, ".rd_gnt"},   32'(rd_gnt),   32'(er));
    chk({tag, ".wr_gnt"},   32'(wr_gnt),   32'(ew));
    chk({tag, ".gnt_id"},   32'(gnt_id),   32'(eid));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_rd = '0; req_wr = '0; rd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    req_id = 16'hDCBA;
    t_ccd = 4'd2; t_wtr = 4'd0; t_rtw = 4'd0;
    do_reset();

    #1;
    chk("rst.credits", 32'(credits), 32'd4);
    chk("rst.err", 32'(credit_err), 32'd0);
    chk("rst.dir", 32'(dbg_dir), 32'(DIR_RD));
    cyc("rst.idle", 4'b0000, 0, 0, 4'h0);

    // Four reads at tCCD = 2, then credits run out.
    req_rd = 4'b1111;
    cyc("rd0",  4'b0001, 1, 0, 4'hA);
    cyc("gap0", 4'b0000, 0, 0, 4'h0);
    cyc("rd1",  4'b0010, 1, 0, 4'hB);
    cyc("gap1", 4'b0000, 0, 0, 4'h0);
    cyc("rd2",  4'b0100, 1, 0, 4'hC);
    cyc("gap2", 4'b0000, 0, 0, 4'h0);
    cyc("rd3",  4'b1000, 1, 0, 4'hD);
    cyc("gap3", 4'b0000, 0, 0, 4'h0);
    chk("empty.credits", 32'(credits), 32'd0);
    cyc("nocred", 4'b0000, 0, 0, 4'h0);

    // Each rd_done frees one credit; one grant follows it.
    rd_done = 1'b1;
    cyc("done0", 4'b0000, 0, 0, 4'h0);
    rd_done = 1'b0;
    chk("done0.credits", 32'(credits), 32'd1);
    cyc("rdc0", 4'b0001, 1, 0, 4'hA);
    repeat (3) cyc("idle0", 4'b0000, 0, 0, 4'h0);
    rd_done = 1'b1;
    cyc("done1", 4'b0000, 0, 0, 4'h0);
    rd_done = 1'b0;
    chk("done1.credits", 32'(credits), 32'd1);
    cyc("rdc1", 4'b0010, 1, 0, 4'hB);
    chk("rdc1.credits", 32'(credits), 32'd0);

    // Async reset mid-operation with requests still high kills grants at once.
    #2 rst = 1'b1;
    #1;
    chk("arst.rd_gnt", 32'(rd_gnt), 32'd0);
    chk("arst.credits", 32'(credits), 32'd4);

    // Read -> write spacing (tRTW = 3), then write -> read (tWTR = 4).
    t_ccd = 4'd1; t_rtw = 4'd3; t_wtr = 4'd4;
    do_reset();
    req_rd = 4'b0001;
    cyc("rtw.rd", 4'b0001, 1, 0, 4'hA);
    req_rd = 4'b0000; req_wr = 4'b0100;
    cyc("rtw.sw", 4'b0000, 0, 0, 4'h0);
    #1 chk("rtw.dir", 32'(dbg_dir), 32'(DIR_WR));
    cyc("rtw.w1", 4'b0000, 0, 0, 4'h0);
    cyc("rtw.wr", 4'b0100, 0, 1, 4'hC);
    req_wr = 4'b0000; req_rd = 4'b1000;
    cyc("wtr.sw", 4'b0000, 0, 0, 4'h0);
    #1 chk("wtr.dir", 32'(dbg_dir), 32'(DIR_RD));
    cyc("wtr.w1", 4'b0000, 0, 0, 4'h0);
    cyc("wtr.w2", 4'b0000, 0, 0, 4'h0);
    cyc("wtr.rd", 4'b1000, 1, 0, 4'hD);

    // Streak limit: eight reads, switch, the write, then back to reads.
    t_ccd = 4'd1; t_rtw = 4'd0; t_wtr = 4'd0;
    do_reset();
    req_rd = 4'b1111; req_wr = 4'b0010;
    cyc("stk.r0", 4'b0001, 1, 0, 4'hA);
    rd_done = 1'b1;
    for (int i = 1; i < 8; i++)
      cyc("stk.rn", 4'(1 << (i % 4)), 1, 0, 4'(4'hA + (i % 4)));
    rd_done = 1'b0;
    chk("stk.credits", 32'(credits), 32'd3);
    cyc("stk.sw", 4'b0000, 0, 0, 4'h0);
    cyc("stk.wr", 4'b0010, 0, 1, 4'hB);
    req_wr = 4'b0000;
    cyc("stk.back", 4'b0000, 0, 0, 4'h0);
    cyc("stk.rd", 4'b0100, 1, 0, 4'hC);

    // rd_done with all credits free is an error and is otherwise ignored.
    do_reset();
    rd_done = 1'b1;
    @(posedge clk); #1;
    rd_done = 1'b0;
    chk("cerr.credits", 32'(credits), 32'd4);
    chk("cerr.set", 32'(credit_err), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("cerr.sticky", 32'(credit_err), 32'd1);
    do_reset();
    #1 chk("cerr.clear", 32'(credit_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
